// File: rtl/icon_update_ctrl.sv
// icon_update_ctrl
// Accepts icon location/image update requests at any time, holds them in
// shadow registers and commits them to the live registers only at the frame
// boundary, so a visible frame never shows a half-updated icon. Also produces
// the registered icon-window hit flag and icon ROM address for the current
// display pixel.
module icon_update_ctrl #(
    parameter logic [7:0] INIT_X   = 8'd64,
    parameter logic [7:0] INIT_Y   = 8'd64,
    parameter logic [9:0] VIS_ROWS = 10'd480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] pixCol,
    input  logic [9:0] pixRow,
    input  logic       updReq,
    input  logic [7:0] updLocX,
    input  logic [7:0] updLocY,
    input  logic [1:0] updSel,
    output logic       updAck,
    output logic [7:0] locX,
    output logic [7:0] locY,
    output logic [1:0] iconSel,
    output logic [9:0] iconAddr,
    output logic       iconHit,
    output logic       frameTick,
    output logic       updPending,
    output logic [7:0] dropCnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] shadowX;
    logic [7:0] shadowY;
    logic [1:0] shadowSel;

    logic       boundary;
    logic [9:0] colOrg;
    logic [9:0] rowOrg;
    logic [9:0] dc;
    logic [9:0] dr;
    logic       inWin;

    // Saturating increment for the dropped-update counter.
    function automatic logic [7:0] satInc(input logic [7:0] val);
        return (val == 8'hFF) ? val : val + 8'd1;
    endfunction

    // First pixel of the first non-visible row marks the frame boundary.
    assign boundary = (pixRow == VIS_ROWS) && (pixCol == 10'd0);

    // Both PENDING and COMMIT hold an update that is not yet visible.
    assign updPending = (state != IDLE);

    // Icon window: 16x16 pixels whose origin is the committed location scaled by 4.
    // The explicit >= tests reject pixels left/above the origin whose wrapped
    // difference would otherwise look small.
    always_comb begin
        colOrg = {locX, 2'b00};
        rowOrg = {locY, 2'b00};
        dc     = pixCol - colOrg;
        dr     = pixRow - rowOrg;
        inWin  = (pixCol >= colOrg) && (dc <= 10'd15) &&
                 (pixRow >= rowOrg) && (dr <= 10'd15);
    end

    // Update FSM: capture into shadow, overwrite while pending, commit at the boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shadowX   <= 8'd0;
            shadowY   <= 8'd0;
            shadowSel <= 2'd0;
            locX      <= INIT_X;
            locY      <= INIT_Y;
            iconSel   <= 2'd0;
            dropCnt   <= 8'd0;
            updAck    <= 1'b0;
            frameTick <= 1'b0;
        end else begin
            frameTick <= boundary;
            updAck    <= 1'b0;
            case (state)
                IDLE: begin
                    if (updReq) begin
                        shadowX   <= updLocX;
                        shadowY   <= updLocY;
                        shadowSel <= updSel;
                        updAck    <= 1'b1;
                        state     <= PENDING;
                    end
                end
                PENDING: begin
                    // The boundary wins over a simultaneous request; a request
                    // still held is picked up again once back in IDLE.
                    if (boundary) begin
                        state <= COMMIT;
                    end else if (updReq) begin
                        shadowX   <= updLocX;
                        shadowY   <= updLocY;
                        shadowSel <= updSel;
                        updAck    <= 1'b1;
                        dropCnt   <= satInc(dropCnt);
                    end
                end
                COMMIT: begin
                    locX    <= shadowX;
                    locY    <= shadowY;
                    iconSel <= shadowSel;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Registered hit flag and ROM address, one cycle behind the pixel coordinates.
    always_ff @(posedge clk) begin
        if (reset) begin
            iconHit  <= 1'b0;
            iconAddr <= 10'd0;
        end else begin
            iconHit  <= inWin;
            iconAddr <= inWin ? {iconSel, dr[3:0], dc[3:0]} : 10'd0;
        end
    end

endmodule

// File: tb/tb_icon_update_ctrl.sv
// Testbench for icon_update_ctrl: a cycle-level reference model predicts every
// output after each clock edge; predictions are queued when stimulus is driven
// and compared when the DUT outputs for that edge are visible.
module tb_icon_update_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] pixCol;
    logic [9:0] pixRow;
    logic       updReq;
    logic [7:0] updLocX;
    logic [7:0] updLocY;
    logic [1:0] updSel;
    logic       updAck;
    logic [7:0] locX;
    logic [7:0] locY;
    logic [1:0] iconSel;
    logic [9:0] iconAddr;
    logic       iconHit;
    logic       frameTick;
    logic       updPending;
    logic [7:0] dropCnt;

    icon_update_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .pixCol    (pixCol),
        .pixRow    (pixRow),
        .updReq    (updReq),
        .updLocX   (updLocX),
        .updLocY   (updLocY),
        .updSel    (updSel),
        .updAck    (updAck),
        .locX      (locX),
        .locY      (locY),
        .iconSel   (iconSel),
        .iconAddr  (iconAddr),
        .iconHit   (iconHit),
        .frameTick (frameTick),
        .updPending(updPending),
        .dropCnt   (dropCnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ack;
        logic       tick;
        logic       hit;
        logic [9:0] addr;
        logic [7:0] lx;
        logic [7:0] ly;
        logic [1:0] sel;
        logic       pend;
        logic [7:0] drop;
    } exp_t;

    exp_t expQ[$];

    int checks   = 0;
    int failures = 0;

    // Reference model state: 0 = idle, 1 = pending, 2 = commit.
    int mState = 0;
    int mShX = 0, mShY = 0, mShSel = 0;
    int mLocX = 64, mLocY = 64, mSel = 0, mDrop = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic scoreCheck();
        exp_t e;
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            chk("updAck",     32'(updAck),     32'(e.ack));
            chk("frameTick",  32'(frameTick),  32'(e.tick));
            chk("iconHit",    32'(iconHit),    32'(e.hit));
            chk("iconAddr",   32'(iconAddr),   32'(e.addr));
            chk("locX",       32'(locX),       32'(e.lx));
            chk("locY",       32'(locY),       32'(e.ly));
            chk("iconSel",    32'(iconSel),    32'(e.sel));
            chk("updPending", 32'(updPending), 32'(e.pend));
            chk("dropCnt",    32'(dropCnt),    32'(e.drop));
        end
    endtask

    // One clock cycle: check the previous edge's outputs, drive new inputs,
    // and queue the prediction for the coming edge.
    task automatic cyc(input bit rst, input int c, input int r, input bit rq,
                       input int x, input int y, input int s);
        exp_t e;
        int   co, ro;
        bit   bnd;
        @(negedge clk);
        scoreCheck();
        reset   = rst;
        pixCol  = 10'(c);
        pixRow  = 10'(r);
        updReq  = rq;
        updLocX = 8'(x);
        updLocY = 8'(y);
        updSel  = 2'(s);

        e   = '0;
        bnd = (r == 480) && (c == 0);
        co  = mLocX * 4;
        ro  = mLocY * 4;
        if (rst) begin
            mState = 0; mShX = 0; mShY = 0; mShSel = 0;
            mLocX = 64; mLocY = 64; mSel = 0; mDrop = 0;
        end else begin
            e.tick = bnd;
            if (c >= co && c <= co + 15 && r >= ro && r <= ro + 15) begin
                e.hit  = 1'b1;
                e.addr = 10'(mSel * 256 + (r - ro) * 16 + (c - co));
            end
            case (mState)
                0: if (rq) begin
                       mShX = x; mShY = y; mShSel = s;
                       e.ack = 1'b1; mState = 1;
                   end
                1: if (bnd) mState = 2;
                   else if (rq) begin
                       mShX = x; mShY = y; mShSel = s;
                       e.ack = 1'b1;
                       if (mDrop < 255) mDrop++;
                   end
                default: begin
                       mLocX = mShX; mLocY = mShY; mSel = mShSel; mState = 0;
                   end
            endcase
        end
        e.lx   = 8'(mLocX);
        e.ly   = 8'(mLocY);
        e.sel  = 2'(mSel);
        e.pend = (mState != 0);
        e.drop = 8'(mDrop);
        expQ.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pix(input int c, input int r);
        cyc(0, c, r, 0, 0, 0, 0);
    endtask

    task automatic req(input int x, input int y, input int s);
        cyc(0, 0, 0, 1, x, y, s);
    endtask

    task automatic frameEdge();
        cyc(0, 0, 480, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; pixCol = '0; pixRow = '0; updReq = 1'b0;
        updLocX = '0; updLocY = '0; updSel = '0;

        // Reset state
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Window at the reset location (origin 256,256)
        pix(256, 256);
        pix(272, 256);
        pix(271, 271);
        pix(255, 256);
        pix(256, 272);
        pix(260, 255);
        idle(1);

        // Boundary in IDLE with no request: nothing commits
        frameEdge();
        idle(2);

        // Single update, held until the boundary
        req(10, 20, 2);
        idle(3);
        chk("locHold", 32'(locX), 32'd64);
        chk("pendSet", 32'(updPending), 32'd1);
        pix(256, 256);
        frameEdge();
        idle(3);
        chk("locCommit", 32'(locX), 32'd10);
        pix(43, 85);
        pix(40, 80);
        pix(56, 80);
        idle(1);

        // Three requests in one frame: two overwrites
        req(1, 1, 1); idle(1);
        req(2, 2, 1); idle(1);
        req(3, 3, 3); idle(1);
        frameEdge();
        idle(3);
        chk("drop3req", 32'(dropCnt), 32'd2);
        chk("loc3req", 32'(locX), 32'd3);

        // Boundary with a simultaneous request: old shadow commits, request held through COMMIT
        req(7, 8, 1);
        idle(2);
        cyc(0, 0, 480, 1, 9, 9, 2);
        cyc(0, 0, 0, 1, 9, 9, 2);
        cyc(0, 0, 0, 1, 9, 9, 2);
        idle(2);
        frameEdge();
        idle(3);
        chk("heldCommit", 32'(locX), 32'd9);

        // Reset while pending: update discarded
        req(50, 50, 3);
        idle(1);
        cyc(1, 0, 0, 0, 0, 0, 0);
        idle(1);
        frameEdge();
        idle(3);
        chk("rstNoCommit", 32'(locX), 32'd64);

        // 300 overwrites in one frame, then origin-location address check
        req(0, 0, 1);
        for (int i = 0; i < 300; i++) cyc(0, 0, 0, 1, 0, 0, 1);
        idle(2);
        chk("dropSat", 32'(dropCnt), 32'd255);
        frameEdge();
        idle(3);
        pix(3, 5);
        pix(15, 15);
        pix(16, 0);
        idle(2);

        @(negedge clk);
        scoreCheck();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
